// File: rtl/display_pkg.sv
// Shared constants for the multiplexed seven-segment driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package display_pkg;

  typedef logic [6:0] seg_t;

  // Pin polarity of the display board (common-anode, active-low drive)
  localparam logic AN_ON  = 1'b0;
  localparam logic AN_OFF = 1'b1;
  localparam logic DP_ON  = 1'b0;
  localparam logic DP_OFF = 1'b1;

  localparam seg_t SEG_0    = 7'b1000000;
  localparam seg_t SEG_1    = 7'b1111001;
  localparam seg_t SEG_2    = 7'b0100100;
  localparam seg_t SEG_3    = 7'b0110000;
  localparam seg_t SEG_4    = 7'b0011001;
  localparam seg_t SEG_5    = 7'b0010010;
  localparam seg_t SEG_6    = 7'b0000010;
  localparam seg_t SEG_7    = 7'b1111000;
  localparam seg_t SEG_8    = 7'b0000000;
  localparam seg_t SEG_9    = 7'b0010000;
  localparam seg_t SEG_A    = 7'b0001000;
  localparam seg_t SEG_B    = 7'b0000011;
  localparam seg_t SEG_C    = 7'b1000110;
  localparam seg_t SEG_D    = 7'b0100001;
  localparam seg_t SEG_E    = 7'b0000110;
  localparam seg_t SEG_F    = 7'b0001110;
  localparam seg_t SEG_DASH = 7'b0111111;
  localparam seg_t SEG_OFF  = 7'b1111111;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t s;
    case (nib)
      4'h0:    s = SEG_0;
      4'h1:    s = SEG_1;
      4'h2:    s = SEG_2;
      4'h3:    s = SEG_3;
      4'h4:    s = SEG_4;
      4'h5:    s = SEG_5;
      4'h6:    s = SEG_6;
      4'h7:    s = SEG_7;
      4'h8:    s = SEG_8;
      4'h9:    s = SEG_9;
      4'hA:    s = SEG_A;
      4'hB:    s = SEG_B;
      4'hC:    s = SEG_C;
      4'hD:    s = SEG_D;
      4'hE:    s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Nibble to active-low segment pattern; decimal mode shows a dash for 10-15.
module seg7_encode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output seg_t       seg
);

  always_comb begin
    seg = hex_to_seg(nibble);
    if (!hex_mode && (nibble > 4'd9)) begin
      seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/display_7seg_scan.sv
// N-digit multiplexed common-anode seven-segment driver with refresh prescaler,
// leading-zero blanking, per-digit decimal points and a blank cycle at each digit switch.
module display_7seg_scan
  import display_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an
);

  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PRES_W = $clog2(REFRESH_DIV);
  localparam logic [PRES_W-1:0] PRES_MAX = PRES_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(N_DIGITS - 1);

  logic [4*N_DIGITS-1:0] value_q;
  logic [N_DIGITS-1:0]   dp_q;
  logic [PRES_W-1:0]     pres;
  logic [IDX_W-1:0]      idx;

  logic                  tick;
  logic [3:0]            nibble_arr [N_DIGITS];
  logic [N_DIGITS-1:0]   lz_blank;
  logic [N_DIGITS-1:0]   an_drive;
  logic [3:0]            cur_nibble;
  seg_t                  enc_seg;

  assign tick = (pres == PRES_MAX);

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign nibble_arr[gi] = value_q[4*gi +: 4];
      assign an_drive[gi]   = (idx == IDX_W'(gi)) ? AN_ON : AN_OFF;
      // A digit is a leading zero when it and every more significant nibble are zero
      if (gi == 0) begin : g_lsd
        assign lz_blank[gi] = 1'b0;
      end else begin : g_upper
        assign lz_blank[gi] = (value_q[4*N_DIGITS-1:4*gi] == '0);
      end
    end
  endgenerate

  assign cur_nibble = nibble_arr[idx];

  seg7_encode u_encode (
    .nibble   (cur_nibble),
    .hex_mode (hex_mode),
    .seg      (enc_seg)
  );

  // The tick edge itself loads the all-off pattern, so the cycle after every
  // wrap is dark and the next digit appears one cycle later with settled data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      dp_q    <= '0;
      pres    <= '0;
      idx     <= '0;
      seg     <= SEG_OFF;
      dp      <= DP_OFF;
      an      <= '1;
    end else begin
      if (load) begin
        value_q <= value;
        dp_q    <= dp_in;
      end
      if (tick) begin
        pres <= '0;
        idx  <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        seg  <= SEG_OFF;
        dp   <= DP_OFF;
        an   <= '1;
      end else begin
        pres <= pres + 1'b1;
        seg  <= (blank_lz && lz_blank[idx]) ? SEG_OFF : enc_seg;
        dp   <= dp_q[idx] ? DP_ON : DP_OFF;
        an   <= an_drive;
      end
    end
  end

endmodule
